stream_demux_1to4: RTL and testbench
====================================

// Module: stream_demux_1to4
// PURPOSE
//   Buffered 1-to-4 demultiplexer: routes WIDTH-bit words from one valid/ready
//   input stream to one of four output channels (A..D) chosen per word by sel.
//   Each channel owns a small FIFO so a stalled consumer blocks only its own
//   channel. Return path of the 4:1 channel mux in the lab datapath.
// PARAMETERS
//   WIDTH  4  data word width in bits
//   DEPTH  2  entries per channel FIFO; power of 2, >= 2
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   en         in   1        enable; 0 = accept nothing, channels still drain
//   in_valid   in   1        input word present
//   in_ready   out  1        block can accept word this cycle
//   in_data    in   WIDTH    input word
//   in_sel     in   2        destination: 00=A 01=B 10=C 11=D
//   out_valid  out  4        per-channel word present; bit0=A .. bit3=D
//   out_ready  in   4        per-channel consumer ready; bit0=A .. bit3=D
//   out_a      out  WIDTH    channel A head word (out_b, out_c, out_d likewise)
//   busy       out  1        OR of out_valid
// BEHAVIOUR
//   - Reset (async, rst=1): all FIFOs empty, pointers/counts 0, out_valid=0,
//     out_a..out_d=0, busy=0; in_ready=0 while rst=1. Reset mid-transfer drops
//     all buffered words; no partial state survives.
//   - in_ready = en & ~full[in_sel] (combinational; depends on in_sel, not on
//     in_valid). Push when in_valid & in_ready at rising edge.
//   - Pop channel k when out_valid[k] & out_ready[k] at rising edge.
//   - Latency: word pushed at edge N is on out_<k> with out_valid[k]=1 after
//     edge N (visible in cycle N+1); no combinational input-to-output path.
//   - out_<k> shows FIFO head; holds stable while out_valid[k]=1 & ~out_ready[k].
//     When channel empty, out_<k> = 0.
//   - Per channel count 0..DEPTH, width clog2(DEPTH)+1. full = (count==DEPTH),
//     empty = (count==0). Read/write pointers wrap modulo DEPTH.
//   - Same-edge push and pop on one channel: both happen, count unchanged.
//     Full channel: in_ready=0 even if popping that cycle (no bypass).
//   - Pushes to one channel never affect another channel's count/data/valid.
//   - en=0: in_ready=0, out_valid/pops unaffected. en toggling never corrupts.
//   - in_sel/in_data are don't-care when in_valid=0.
//   - Order preserved per channel; no ordering between channels.
// TESTING
//   1 rst=1 mid-stream with 2 words in A -> out_valid=0000, out_a=0, busy=0
//     immediately (async), stays after release.
//   2 out_ready=1111; push 4'h5 sel=00, 4'hA sel=01, 4'h3 sel=10, 4'hC sel=11
//     on consecutive edges -> each out_valid bit rises one cycle after its push
//     with out_a=5, out_b=A, out_c=3, out_d=C.
//   3 out_ready[2]=0; push 4'h1,4'h2 sel=10 -> in_ready=0 for sel=10 but 1 for
//     sel=00; push 4'h7 sel=00 passes to A; raise out_ready[2] -> C yields 1 then 2.
//   4 Channel B full (DEPTH=2), same cycle out_ready[1]=1 and push sel=01 ->
//     in_ready=0, no push; next cycle count=1, push accepted.
//   5 Channel D count=1, push and pop same edge -> count stays 1, new word
//     follows old; repeat 8 words -> pointer wrap, order intact.
//   6 en=0 with in_valid=1 for 5 cycles -> in_ready=0, no count change, queued
//     words still drain; en=1 -> next word accepted that edge.

Source files
------------

// File: rtl/stream_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1to4
// Purpose  : Buffered 1-to-4 stream demultiplexer. Each WIDTH-bit word on the
//            valid/ready input is routed to channel A..D chosen by in_sel.
//            Every channel has its own DEPTH-entry FIFO, so a stalled
//            consumer only blocks words addressed to its own channel.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active-high
//            en         enable; 0 = accept nothing, channels still drain
//            in_valid   input word present
//            in_ready   block can accept a word for in_sel this cycle
//            in_data    input word
//            in_sel     destination channel: 0=A 1=B 2=C 3=D
//            out_valid  per-channel word present (bit0=A .. bit3=D)
//            out_ready  per-channel consumer ready (bit0=A .. bit3=D)
//            out_a..d   per-channel FIFO head word (0 when channel empty)
//            busy       OR of out_valid
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1to4 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);      // pointer width
  localparam int CW = $clog2(DEPTH) + 1;  // count width, holds 0..DEPTH

  logic [3:0]            full;
  logic [3:0]            empty;
  logic [3:0][WIDTH-1:0] head;

  // Readiness looks only at the addressed channel, never at in_valid, and
  // there is no bypass: a full channel refuses even while it is popping.
  // Held low during reset so nothing is accepted while state is cleared.
  assign in_ready = en & ~rst & ~full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;
    logic [PW-1:0]               wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]               rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]               count_d, count_q;
    logic                        push;
    logic                        pop;

    assign empty[k]     = (count_q == '0);
    assign full[k]      = (count_q == CW'(DEPTH));
    assign push         = in_valid & in_ready & (in_sel == 2'(k));
    assign pop          = ~empty[k] & out_ready[k];
    assign out_valid[k] = ~empty[k];
    assign head[k]      = empty[k] ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end
  end

  assign out_a = head[0];
  assign out_b = head[1];
  assign out_c = head[2];
  assign out_d = head[3];
  assign busy  = |out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1to4
// Purpose  : Directed self-checking bench for stream_demux_1to4 (WIDTH=4,
//            DEPTH=2). Inputs change 1 time unit after each rising edge;
//            outputs are checked there, clear of the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  stream_demux_1to4 #(.WIDTH(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_sel = 2'd0;
    out_ready = 4'b0000;
    #1;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // ---- 1: async reset with two words queued in A ----
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_a_queued", out_valid, 4'b0001);
    chk("t1_a_head", out_a, 4'h5);
    chk("t1_a_full", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_valid", out_valid, 4'b0000);
    chk("t1_async_out_a", out_a, 4'h0);
    chk("t1_async_busy", busy, 1'b0);
    chk("t1_async_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_after_valid", out_valid, 4'b0000);
    chk("t1_after_out_a", out_a, 4'h0);
    chk("t1_after_in_ready", in_ready, 1'b1);

    // ---- 2: one word to each channel, consumers always ready ----
    out_ready = 4'b1111;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h5;
    #1;
    chk("t2_in_ready", in_ready, 1'b1);
    tick();
    chk("t2_valid_a", out_valid, 4'b0001);
    chk("t2_out_a", out_a, 4'h5);
    in_sel = 2'd1; in_data = 4'hA;
    tick();
    chk("t2_valid_b", out_valid, 4'b0010);
    chk("t2_out_b", out_b, 4'hA);
    chk("t2_a_drained", out_a, 4'h0);
    in_sel = 2'd2; in_data = 4'h3;
    tick();
    chk("t2_valid_c", out_valid, 4'b0100);
    chk("t2_out_c", out_c, 4'h3);
    in_sel = 2'd3; in_data = 4'hC;
    tick();
    chk("t2_valid_d", out_valid, 4'b1000);
    chk("t2_out_d", out_d, 4'hC);
    in_valid = 1'b0;
    tick();
    chk("t2_empty", out_valid, 4'b0000);
    chk("t2_busy", busy, 1'b0);

    // ---- 3: stalled C blocks only C ----
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    #1;
    chk("t3_c_full_ready", in_ready, 1'b0);
    in_sel = 2'd0; in_data = 4'h7;
    #1;
    chk("t3_a_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t3_valid_ac", out_valid, 4'b0101);
    chk("t3_out_a", out_a, 4'h7);
    chk("t3_out_c_hold", out_c, 4'h1);
    tick();
    chk("t3_a_popped", out_valid, 4'b0100);
    chk("t3_out_c_stable", out_c, 4'h1);
    out_ready = 4'b1111;
    tick();
    chk("t3_out_c_second", out_c, 4'h2);
    chk("t3_valid_c", out_valid, 4'b0100);
    tick();
    chk("t3_drained", out_valid, 4'b0000);

    // ---- 4: full B refuses a push even while popping ----
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h8;
    tick();
    in_data = 4'h9;
    tick();
    in_data = 4'h4; out_ready = 4'b0010;
    #1;
    chk("t4_full_no_bypass", in_ready, 1'b0);
    tick();
    chk("t4_out_b_after_pop", out_b, 4'h9);
    chk("t4_valid_b", out_valid, 4'b0010);
    chk("t4_ready_again", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t4_out_b_new", out_b, 4'h4);
    chk("t4_valid_b_new", out_valid, 4'b0010);
    tick();
    chk("t4_drained", out_valid, 4'b0000);

    // ---- 5: D at count 1, push+pop every edge across pointer wrap ----
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 4'hF;
    tick();
    out_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i + 1);
      #1;
      chk("t5_ready", in_ready, 1'b1);
      tick();
      chk("t5_out_d", out_d, 32'(i + 1));
      chk("t5_valid", out_valid, 4'b1000);
    end
    in_valid = 1'b0;
    tick();
    chk("t5_drained", out_valid, 4'b0000);

    // ---- 6: en=0 blocks input, queued words still drain ----
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hB;
    tick();
    in_data = 4'hD;
    tick();
    en = 1'b0; in_sel = 2'd1; in_data = 4'hE;
    #1;
    chk("t6_en_off_ready", in_ready, 1'b0);
    tick();
    chk("t6_hold_valid", out_valid, 4'b0001);
    chk("t6_hold_out_a", out_a, 4'hB);
    out_ready = 4'b0001;
    tick();
    chk("t6_drain_out_a", out_a, 4'hD);
    tick();
    chk("t6_drained", out_valid, 4'b0000);
    tick();
    tick();
    chk("t6_no_push", out_valid, 4'b0000);
    chk("t6_still_blocked", in_ready, 1'b0);
    en = 1'b1;
    #1;
    chk("t6_en_on_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t6_accepted_valid", out_valid, 4'b0010);
    chk("t6_accepted_out_b", out_b, 4'hE);
    out_ready = 4'b1111;
    tick();
    chk("t6_final_empty", out_valid, 4'b0000);
    chk("t6_final_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
